cache_ctrl_nway: RTL and testbench

Parametrised N-way set-associative write-back cache controller: successor of the current 2-way FSM, generalised in associativity, line length and memory latency. Sits between the pipeline memory stage and the cache data/tag arrays plus banked main memory. Adds a latched victim way, invalid-first/round-robin replacement, pipelined line fill with in-flight tracking, and per-way write enables on write hits.

---
 rtl/cache_ctrl_nway.sv | 241 ++++++++++++++++++++++++
 tb/tb_cache_ctrl_nway.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_nway.sv
// ---------------------------------------------------------------------------
// cache_ctrl_nway
//
// N-way set-associative write-back cache controller. Sits between the
// pipeline memory stage, the cache data/tag arrays and banked main memory.
// A request is tag-compared across all ways. A hit completes in one cycle.
// A miss latches a victim way, chosen as the lowest invalid way or else the
// round-robin pointer. If the victim is dirty its line is written back. The
// line is then refilled through a pipelined read that tracks the words in
// flight, and the request is retried as a hit.
//
// Parameters
//   WAYS     associativity (power of two, 2..8)
//   WORDS    16-bit words per line (power of two, 2..8)
//   MEM_LAT  cycles from an accepted memory read to its data (1..4)
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   memRead/memWrite  pipeline request (valid when exactly one is high)
//   c_hit/c_valid/c_dirty  per-way tag-compare results
//   m_stall           memory did not accept this cycle's request
//   c_comp, c_write   per-way compare / write enables
//   c_offsetSel       cache word byte offset (all ones when unused)
//   m_offsetSel       memory word byte offset (all ones when unused)
//   m_read, m_write   memory request strobes
//   m_addrSel         1 = victim tag address, 0 = request address
//   c_dataInSel       1 = cache data from memory, 0 = from pipeline
//   victimSel         latched victim way
//   control_stall     stall the pipeline
//   control_done      one-cycle access-complete pulse
//   no_hit            with control_done: access missed at least once
// ---------------------------------------------------------------------------
module cache_ctrl_nway #(
  parameter  int WAYS    = 2,
  parameter  int WORDS   = 4,
  parameter  int MEM_LAT = 2,
  localparam int VW      = $clog2(WAYS),
  localparam int OW      = $clog2(WORDS) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            memRead,
  input  logic            memWrite,
  input  logic [WAYS-1:0] c_hit,
  input  logic [WAYS-1:0] c_valid,
  input  logic [WAYS-1:0] c_dirty,
  input  logic            m_stall,
  output logic [WAYS-1:0] c_comp,
  output logic [WAYS-1:0] c_write,
  output logic [OW-1:0]   c_offsetSel,
  output logic [OW-1:0]   m_offsetSel,
  output logic            m_read,
  output logic            m_write,
  output logic            m_addrSel,
  output logic            c_dataInSel,
  output logic [VW-1:0]   victimSel,
  output logic            control_stall,
  output logic            control_done,
  output logic            no_hit
);

  localparam int WW = $clog2(WORDS);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COMPARE = 3'd1;
  localparam logic [2:0] S_WB      = 3'd2;
  localparam logic [2:0] S_RD      = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;

  logic [2:0]         state, state_nxt;
  logic [WW-1:0]      wc, wc_nxt;
  logic [MEM_LAT-1:0] pipe_vld, pipe_vld_nxt;
  logic [WW-1:0]      pipe_idx [MEM_LAT];
  logic [VW-1:0]      rr;
  logic [VW-1:0]      victim;
  logic [VW-1:0]      victim_pick;
  logic               miss;

  logic req_valid;
  logic hit;
  logic last_word;
  logic push;
  logic fill;
  logic victim_dirty;

  assign req_valid = memRead ^ memWrite;
  assign hit       = |(c_hit & c_valid);
  assign last_word = (wc == WW'(WORDS - 1));
  // A read beat enters the latency pipe only when memory accepts it.
  assign push      = (state == S_RD) && !m_stall;
  // The oldest pipe stage holds the word whose data returns this cycle.
  assign fill      = pipe_vld[MEM_LAT-1] && ((state == S_RD) || (state == S_DRAIN));

  // Lowest-index invalid way wins; a full set falls back to round-robin.
  always_comb begin
    logic found;
    victim_pick = rr;
    found       = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (!c_valid[i] && !found) begin
        victim_pick = VW'(i);
        found       = 1'b1;
      end
    end
  end

  assign victim_dirty = c_valid[victim_pick] & c_dirty[victim_pick];

  // Shift the in-flight valid bits one stage per cycle. Words already in
  // flight keep moving while memory stalls new requests.
  always_comb begin
    pipe_vld_nxt    = '0;
    pipe_vld_nxt[0] = push;
    for (int i = 1; i < MEM_LAT; i++) begin
      pipe_vld_nxt[i] = pipe_vld[i-1];
    end
  end

  // NOTE: every variable assigned in an always_comb block gets a default at
  // the top, so no path through the case statement can leave it unassigned
  // and infer a latch.
  always_comb begin
    state_nxt = state;
    wc_nxt    = wc;
    case (state)
      S_IDLE: begin
        if (req_valid) state_nxt = S_COMPARE;
      end
      S_COMPARE: begin
        if (!req_valid || hit) state_nxt = S_IDLE;
        else if (victim_dirty)  state_nxt = S_WB;
        else                    state_nxt = S_RD;
      end
      S_WB: begin
        if (!m_stall) begin
          if (last_word) begin
            wc_nxt    = '0;
            state_nxt = S_RD;
          end else begin
            wc_nxt = wc + WW'(1);
          end
        end
      end
      S_RD: begin
        if (!m_stall) begin
          if (last_word) begin
            wc_nxt    = '0;
            state_nxt = S_DRAIN;
          end else begin
            wc_nxt = wc + WW'(1);
          end
        end
      end
      S_DRAIN: begin
        // Leave once the word returning this cycle is the last one in
        // flight, so the retry compare never shares a cycle with a fill.
        if (pipe_vld_nxt == '0) state_nxt = S_COMPARE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the values from before the clock edge, whatever the order of
  // the statements.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      wc       <= '0;
      pipe_vld <= '0;
      rr       <= '0;
      victim   <= '0;
      miss     <= 1'b0;
    end else begin
      state    <= state_nxt;
      wc       <= wc_nxt;
      pipe_vld <= pipe_vld_nxt;
      if ((state == S_IDLE) && req_valid) miss <= 1'b0;
      if ((state == S_COMPARE) && req_valid && !hit) begin
        miss   <= 1'b1;
        victim <= victim_pick;
      end
      // Advance the round-robin pointer once per completed fill.
      if ((state == S_DRAIN) && (state_nxt == S_COMPARE)) rr <= rr + VW'(1);
    end
  end

  // NOTE: the word indices in the latency pipe are not reset. They are only
  // used when the matching valid bit is set, and those bits are reset.
  always_ff @(posedge clk) begin
    pipe_idx[0] <= wc;
    for (int i = 1; i < MEM_LAT; i++) begin
      pipe_idx[i] <= pipe_idx[i-1];
    end
  end

  always_comb begin
    c_comp       = '0;
    c_write      = '0;
    c_offsetSel  = '1;
    m_offsetSel  = '1;
    m_read       = 1'b0;
    m_write      = 1'b0;
    m_addrSel    = 1'b0;
    c_dataInSel  = 1'b0;
    control_done = 1'b0;
    no_hit       = 1'b0;
    case (state)
      S_COMPARE: begin
        c_comp = '1;
        if (req_valid && hit) begin
          control_done = 1'b1;
          no_hit       = miss;
          c_write      = {WAYS{memWrite}} & c_hit & c_valid;
        end
      end
      S_WB: begin
        m_write     = 1'b1;
        m_addrSel   = 1'b1;
        c_offsetSel = {wc, 1'b0};
        m_offsetSel = {wc, 1'b0};
      end
      S_RD: begin
        m_read      = 1'b1;
        m_offsetSel = {wc, 1'b0};
      end
      default: ;
    endcase
    // A returning fill word owns the cache write port.
    if (fill) begin
      c_write     = WAYS'(1) << victim;
      c_dataInSel = 1'b1;
      c_offsetSel = {pipe_idx[MEM_LAT-1], 1'b0};
      c_comp      = '0;
    end
  end

  assign victimSel     = victim;
  assign control_stall = (state != S_IDLE) && !((state == S_COMPARE) && hit);

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// ---------------------------------------------------------------------------
// tb_cache_ctrl_nway
//
// Directed bench for cache_ctrl_nway with WAYS=4, WORDS=4, MEM_LAT=2.
// Inputs change 1 ns after the rising edge and outputs are sampled on the
// falling edge. Expected values are hand-derived from the controller's
// behaviour: hit latency, miss fill timing, write-back with memory stalls,
// round-robin replacement, and reset in the middle of a fill.
// ---------------------------------------------------------------------------
module tb_cache_ctrl_nway;

  localparam int WAYS    = 4;
  localparam int WORDS   = 4;
  localparam int MEM_LAT = 2;
  localparam int VW      = 2;
  localparam int OW      = 3;

  logic            clk;
  logic            rst;
  logic            memRead;
  logic            memWrite;
  logic [WAYS-1:0] c_hit;
  logic [WAYS-1:0] c_valid;
  logic [WAYS-1:0] c_dirty;
  logic            m_stall;
  logic [WAYS-1:0] c_comp;
  logic [WAYS-1:0] c_write;
  logic [OW-1:0]   c_offsetSel;
  logic [OW-1:0]   m_offsetSel;
  logic            m_read;
  logic            m_write;
  logic            m_addrSel;
  logic            c_dataInSel;
  logic [VW-1:0]   victimSel;
  logic            control_stall;
  logic            control_done;
  logic            no_hit;

  int checks = 0;
  int errors = 0;

  cache_ctrl_nway #(
    .WAYS   (WAYS),
    .WORDS  (WORDS),
    .MEM_LAT(MEM_LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .c_hit        (c_hit),
    .c_valid      (c_valid),
    .c_dirty      (c_dirty),
    .m_stall      (m_stall),
    .c_comp       (c_comp),
    .c_write      (c_write),
    .c_offsetSel  (c_offsetSel),
    .m_offsetSel  (m_offsetSel),
    .m_read       (m_read),
    .m_write      (m_write),
    .m_addrSel    (m_addrSel),
    .c_dataInSel  (c_dataInSel),
    .victimSel    (victimSel),
    .control_stall(control_stall),
    .control_done (control_done),
    .no_hit       (no_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Every enable/strobe low, both offsets at the all-ones idle code.
  task automatic check_idle(input string tag);
    logic [20:0] obs;
    obs = {c_comp, c_write, m_read, m_write, m_addrSel, c_dataInSel,
           control_stall, control_done, no_hit, c_offsetSel, m_offsetSel};
    check(tag, 32'(obs), 32'({8'h00, 7'b0000000, 3'b111, 3'b111}));
  endtask

  // Four RD cycles followed by two DRAIN cycles, with no memory stalls.
  // Reads issue at offsets 0,2,4,6; each word returns MEM_LAT=2 cycles later
  // into the victim way.
  task automatic fill_phase(input string tag, input logic [1:0] way);
    logic [3:0] cw;
    cw = 4'b0001 << way;
    for (int k = 0; k < WORDS + MEM_LAT; k++) begin
      next_cycle();
      sample();
      if (k == 0) check({tag, "_victim"}, 32'(victimSel), 32'(way));
      check($sformatf("%s_mread_%0d", tag, k), 32'(m_read), (k < 4) ? 32'd1 : 32'd0);
      check($sformatf("%s_moff_%0d", tag, k), 32'(m_offsetSel),
            (k < 4) ? 32'(2 * k) : 32'd7);
      check($sformatf("%s_cwr_%0d", tag, k), 32'(c_write), (k >= 2) ? 32'(cw) : 32'd0);
      check($sformatf("%s_coff_%0d", tag, k), 32'(c_offsetSel),
            (k >= 2) ? 32'(2 * (k - 2)) : 32'd7);
      check($sformatf("%s_dsel_%0d", tag, k), 32'(c_dataInSel), (k >= 2) ? 32'd1 : 32'd0);
      check($sformatf("%s_stall_%0d", tag, k), 32'(control_stall), 32'd1);
    end
  endtask

  // Clean read miss on a full set, refilled and retried as a hit.
  task automatic clean_miss(input string tag, input logic [1:0] way);
    next_cycle();
    memRead = 1'b1; memWrite = 1'b0;
    c_valid = 4'hF; c_hit = 4'h0; c_dirty = 4'h0;
    sample();
    next_cycle();
    sample();
    check({tag, "_cmp_mwr"}, 32'(m_write), 32'd0);
    fill_phase(tag, way);
    next_cycle();
    c_hit = 4'b0001 << way;
    sample();
    check({tag, "_done"}, 32'(control_done), 32'd1);
    check({tag, "_nohit"}, 32'(no_hit), 32'd1);
    next_cycle();
    memRead = 1'b0; c_hit = 4'h0;
    sample();
  endtask

  logic       wb_stall [6];
  logic [2:0] wb_off   [6];

  initial begin
    wb_stall = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    wb_off   = '{3'd0, 3'd2, 3'd2, 3'd2, 3'd4, 3'd6};

    rst = 1'b0;
    memRead = 1'b0; memWrite = 1'b0;
    c_hit = '0; c_valid = '0; c_dirty = '0; m_stall = 1'b0;

    // Reset state
    sample();
    check_idle("reset_outputs");
    check("reset_victim", 32'(victimSel), 32'd0);
    next_cycle();
    rst = 1'b1;

    // Read hit on way 2
    next_cycle();
    memRead = 1'b1; c_valid = 4'hF; c_hit = 4'b0100;
    sample();
    check("rdhit_t_stall", 32'(control_stall), 32'd0);
    check("rdhit_t_done", 32'(control_done), 32'd0);
    next_cycle();
    sample();
    check("rdhit_comp", 32'(c_comp), 32'hF);
    check("rdhit_done", 32'(control_done), 32'd1);
    check("rdhit_nohit", 32'(no_hit), 32'd0);
    check("rdhit_cwr", 32'(c_write), 32'd0);
    check("rdhit_stall", 32'(control_stall), 32'd0);
    next_cycle();
    memRead = 1'b0; c_hit = 4'h0;
    sample();
    check("rdhit_t2_done", 32'(control_done), 32'd0);

    // Write hit on way 3
    next_cycle();
    memWrite = 1'b1; c_hit = 4'b1000;
    sample();
    next_cycle();
    sample();
    check("wrhit_cwr", 32'(c_write), 32'b1000);
    check("wrhit_dsel", 32'(c_dataInSel), 32'd0);
    check("wrhit_done", 32'(control_done), 32'd1);
    next_cycle();
    memWrite = 1'b0; c_hit = 4'h0;
    sample();
    check("wrhit_t2_cwr", 32'(c_write), 32'd0);

    // Read miss, way 1 invalid: clean fill into way 1, done at t+8
    next_cycle();
    memRead = 1'b1; c_valid = 4'b1101; c_hit = 4'h0;
    sample();
    next_cycle();
    sample();
    check("rdmiss_cmp_done", 32'(control_done), 32'd0);
    check("rdmiss_cmp_stall", 32'(control_stall), 32'd1);
    fill_phase("rdmiss", 2'd1);
    check("rdmiss_addrsel", 32'(m_addrSel), 32'd0);
    next_cycle();
    c_valid = 4'hF; c_hit = 4'b0010;
    sample();
    check("rdmiss_done", 32'(control_done), 32'd1);
    check("rdmiss_nohit", 32'(no_hit), 32'd1);
    check("rdmiss_retry_cwr", 32'(c_write), 32'd0);
    check("rdmiss_retry_victim", 32'(victimSel), 32'd1);
    next_cycle();
    memRead = 1'b0; c_hit = 4'h0;
    sample();
    check("rdmiss_after_done", 32'(control_done), 32'd0);
    check("rdmiss_after_stall", 32'(control_stall), 32'd0);

    // Write miss on a full set with a dirty victim (rr is now 1); memory
    // stalls twice on write-back word 1.
    next_cycle();
    memWrite = 1'b1; c_valid = 4'hF; c_dirty = 4'hF; c_hit = 4'h0;
    sample();
    next_cycle();
    sample();
    check("wbmiss_cmp_done", 32'(control_done), 32'd0);
    for (int j = 0; j < 6; j++) begin
      next_cycle();
      m_stall = wb_stall[j];
      sample();
      if (j == 0) check("wb_victim", 32'(victimSel), 32'd1);
      check($sformatf("wb_mwr_%0d", j), 32'(m_write), 32'd1);
      check($sformatf("wb_asel_%0d", j), 32'(m_addrSel), 32'd1);
      check($sformatf("wb_moff_%0d", j), 32'(m_offsetSel), 32'(wb_off[j]));
      check($sformatf("wb_coff_%0d", j), 32'(c_offsetSel), 32'(wb_off[j]));
      check($sformatf("wb_mrd_%0d", j), 32'(m_read), 32'd0);
    end
    m_stall = 1'b0;
    fill_phase("wbfill", 2'd1);
    next_cycle();
    c_hit = 4'b0010;
    sample();
    check("wbmiss_done", 32'(control_done), 32'd1);
    check("wbmiss_nohit", 32'(no_hit), 32'd1);
    check("wbmiss_retry_cwr", 32'(c_write), 32'b0010);
    check("wbmiss_retry_dsel", 32'(c_dataInSel), 32'd0);
    next_cycle();
    memWrite = 1'b0; c_hit = 4'h0; c_dirty = 4'h0;
    sample();

    // rr advanced to 2: the next full-set miss picks way 2. Reset lands
    // in RD with two reads in flight.
    next_cycle();
    memRead = 1'b1; c_valid = 4'hF; c_hit = 4'h0;
    sample();
    next_cycle();
    sample();
    next_cycle();
    sample();
    check("rr_step_victim", 32'(victimSel), 32'd2);
    check("rr_step_mread", 32'(m_read), 32'd1);
    next_cycle();
    sample();
    #2;
    rst = 1'b0;
    memRead = 1'b0;
    next_cycle();
    sample();
    check_idle("midfill_reset_outputs");
    check("midfill_reset_victim", 32'(victimSel), 32'd0);
    next_cycle();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      sample();
      check($sformatf("post_reset_cwr_%0d", k), 32'(c_write), 32'd0);
      check_idle($sformatf("post_reset_idle_%0d", k));
    end

    // Both request lines high: the controller stays idle
    next_cycle();
    memRead = 1'b1; memWrite = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sample();
      check($sformatf("both_req_comp_%0d", k), 32'(c_comp), 32'd0);
      check($sformatf("both_req_stall_%0d", k), 32'(control_stall), 32'd0);
      next_cycle();
    end
    memRead = 1'b0; memWrite = 1'b0;

    // Five full-set misses from rr=0: victims 0,1,2,3,0
    clean_miss("rr0", 2'd0);
    clean_miss("rr1", 2'd1);
    clean_miss("rr2", 2'd2);
    clean_miss("rr3", 2'd3);
    clean_miss("rr4", 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
